// File: rtl/ptp_cap_pkg.sv
// ptp_cap_pkg: shared state encoding, eop byte-enable decode and drop counter limit
package ptp_cap_pkg;
  typedef enum logic [2:0] {IDLE, CAPTURE, COMMIT, HOLD, DROP} state_t;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;
  function automatic logic [3:0] empty_be(input logic [1:0] empty);
    return 4'b1111 << empty;
  endfunction
endpackage

// File: rtl/ptp_rx_capture.sv
// ptp_rx_capture: writes one Avalon-ST frame into a byte-enabled RAM, holds it for host reads, drops oversize frames
module ptp_rx_capture
  import ptp_cap_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [1:0]        in_empty,
  output logic              in_ready,
  output logic [31:0]       ram_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [3:0]        ram_byteena,
  input  logic [31:0]       ram_q,
  output logic              frame_ready,
  output logic [ADDR_W+2:0] frame_len,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  input  logic              frame_release,
  output logic [15:0]       drop_count
);
  state_t state, state_nx;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0] last_empty;
  logic [RD_LAT-1:0] rd_pipe;
  logic acc, start, ovf, wr, drop_inc, ready_d;
  assign acc = in_valid & in_ready;
  assign start = acc & in_sop;
  // wr_ptr carries one extra bit so a full 2**ADDR_W-word frame is still legal
  assign ovf = acc & ~in_sop & (state == CAPTURE) & wr_ptr[ADDR_W];
  assign wr = start | (acc & (state == CAPTURE) & ~ovf);
  assign drop_inc = (start & (state == CAPTURE)) | ovf;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (start) state_nx = in_eop ? COMMIT : CAPTURE;
    else
      case (state)
        CAPTURE: state_nx = ovf ? (in_eop ? IDLE : DROP) : (acc & in_eop) ? COMMIT : CAPTURE;
        COMMIT:  state_nx = HOLD;
        HOLD:    state_nx = frame_release ? IDLE : HOLD;
        DROP:    state_nx = (acc & in_eop) ? IDLE : DROP;
        default: state_nx = state;
      endcase
  end
  always_comb begin
    ready_d = (state_nx == IDLE) | (state_nx == CAPTURE) | (state_nx == DROP);
    frame_ready = state == HOLD;
    ram_address = frame_ready ? rd_addr : wr_addr;
    rd_valid = rd_pipe[RD_LAT-1];
    rd_data = rd_valid ? ram_q : '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      in_ready <= 1'b0;
      ram_wren <= 1'b0;
      wr_addr <= '0;
      ram_data <= '0;
      ram_byteena <= '0;
      wr_ptr <= '0;
      last_empty <= '0;
      frame_len <= '0;
      drop_count <= '0;
      rd_pipe <= '0;
    end else begin
      in_ready <= ready_d;
      ram_wren <= wr;
      if (wr) begin
        wr_addr <= start ? '0 : wr_ptr[ADDR_W-1:0];
        ram_data <= in_data;
        ram_byteena <= in_eop ? empty_be(in_empty) : 4'b1111;
        wr_ptr <= start ? (ADDR_W+1)'(1) : wr_ptr + 1'b1;
        if (in_eop) last_empty <= in_empty;
      end
      if (state == COMMIT) frame_len <= {wr_ptr, 2'b00} - (ADDR_W+3)'(last_empty);
      if (drop_inc && drop_count != DROP_MAX) drop_count <= drop_count + 1'b1;
      rd_pipe <= (rd_pipe << 1) | RD_LAT'(rd_req & frame_ready);
    end
endmodule

// File: tb/tb_ptp_rx_capture.sv
// tb_ptp_rx_capture: directed vectors for frame capture, hold/read, drop and reset behaviour
module tb_ptp_rx_capture;
  logic clock = 0, reset = 1;
  logic [31:0] in_data;
  logic in_valid, in_sop, in_eop, in_ready;
  logic [1:0] in_empty;
  logic [31:0] ram_data, ram_q, rd_data;
  logic [8:0] ram_address, rd_addr;
  logic ram_wren, frame_ready, rd_req, rd_valid, frame_release;
  logic [3:0] ram_byteena;
  logic [11:0] frame_len;
  logic [15:0] drop_count;
  int checks = 0, errors = 0;

  ptp_rx_capture #(.ADDR_W(9), .RD_LAT(2)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_empty(in_empty), .in_ready(in_ready), .ram_data(ram_data),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_byteena(ram_byteena), .ram_q(ram_q),
    .frame_ready(frame_ready), .frame_len(frame_len), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_release(frame_release), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [512];
  logic [31:0] q1, q2;
  assign ram_q = q2;
  always @(posedge clock) begin
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteena[b]) mem[ram_address][b*8 +: 8] <= ram_data[b*8 +: 8];
    q1 <= mem[ram_address];
    q2 <= q1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock); #1;
  endtask

  task automatic send(input logic sop, input logic eop, input logic [1:0] emp, input logic [31:0] d);
    int n = 0;
    in_valid = 1; in_sop = sop; in_eop = eop; in_empty = emp; in_data = d;
    while (!in_ready && n < 50) begin step; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    step;
    in_valid = 0; in_sop = 0; in_eop = 0; in_empty = 0;
  endtask

  task automatic release_frame;
    frame_release = 1; step; frame_release = 0;
    chk("release_frame_ready", frame_ready, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  empty;
    logic [3:0]  be;
    logic [11:0] len;
  } vec_t;
  vec_t vt[4];
  logic [31:0] exp_rd[3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'hA1B2C3D4, 2'd0, 4'b1111, 12'd4};
    vt[1] = '{32'h01020304, 2'd1, 4'b1110, 12'd3};
    vt[2] = '{32'hF0E0D0C0, 2'd2, 4'b1100, 12'd2};
    vt[3] = '{32'h5A6B7C8D, 2'd3, 4'b1000, 12'd1};
    exp_rd[0] = 32'h11223344; exp_rd[1] = 32'h55667788; exp_rd[2] = 32'h99AA0000;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    in_valid = 0; in_sop = 0; in_eop = 0; in_empty = 0; in_data = 0;
    rd_req = 0; rd_addr = 0; frame_release = 0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_rd_valid", rd_valid, 0);
    @(posedge clock); #1 reset = 0;
    step;
    chk("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      send(1, 1, vt[i].empty, vt[i].data);
      chk($sformatf("v%0d_wren", i), ram_wren, 1);
      chk($sformatf("v%0d_addr", i), ram_address, 0);
      chk($sformatf("v%0d_be", i), ram_byteena, vt[i].be);
      chk($sformatf("v%0d_data", i), ram_data, vt[i].data);
      chk($sformatf("v%0d_commit_ready", i), in_ready, 0);
      chk($sformatf("v%0d_commit_fr", i), frame_ready, 0);
      step;
      chk($sformatf("v%0d_frame_ready", i), frame_ready, 1);
      chk($sformatf("v%0d_frame_len", i), frame_len, vt[i].len);
      release_frame;
    end

    send(0, 1, 0, 32'hBAD0BAD0);
    chk("nosop_wren", ram_wren, 0);
    step;
    chk("nosop_frame_ready", frame_ready, 0);

    send(1, 0, 0, 32'h11223344);
    chk("f3_w0_addr", ram_address, 0);
    send(0, 0, 0, 32'h55667788);
    chk("f3_w1_addr", ram_address, 1);
    chk("f3_w1_be", ram_byteena, 4'b1111);
    send(0, 1, 2, 32'h99AABBCC);
    chk("f3_w2_addr", ram_address, 2);
    chk("f3_w2_be", ram_byteena, 4'b1100);
    chk("f3_commit_fr", frame_ready, 0);
    step;
    chk("f3_frame_ready", frame_ready, 1);
    chk("f3_frame_len", frame_len, 10);
    for (int k = 0; k < 6; k++) begin
      rd_req = k < 3;
      rd_addr = 9'(k);
      chk($sformatf("rd%0d_valid", k), rd_valid, k >= 2 && k < 5);
      if (k >= 2 && k < 5) chk($sformatf("rd%0d_data", k), rd_data, exp_rd[k-2]);
      chk($sformatf("rd%0d_in_ready", k), in_ready, 0);
      step;
    end
    rd_req = 0;
    release_frame;

    rd_req = 1;
    for (int k = 0; k < 4; k++) begin
      step;
      chk($sformatf("idle_rd%0d_valid", k), rd_valid, 0);
    end
    rd_req = 0;

    send(1, 0, 0, 32'hA0A0A0A0);
    send(0, 0, 0, 32'hA1A1A1A1);
    send(1, 0, 0, 32'hB0B0B0B0);
    chk("restart_drop_count", drop_count, 1);
    chk("restart_addr", ram_address, 0);
    chk("restart_wren", ram_wren, 1);
    send(0, 1, 0, 32'hB1B1B1B1);
    chk("restart_eop_addr", ram_address, 1);
    step;
    chk("restart_frame_len", frame_len, 8);
    rd_req = 1; rd_addr = 0; frame_release = 1;
    step;
    rd_req = 0; frame_release = 0;
    chk("inflight_fr", frame_ready, 0);
    step;
    chk("inflight_valid", rd_valid, 1);
    chk("inflight_data", rd_data, 32'hB0B0B0B0);

    send(1, 0, 0, 32'd0);
    for (int i = 1; i < 512; i++) send(0, 0, 0, 32'(i));
    chk("ovf_last_addr", ram_address, 511);
    send(0, 0, 0, 32'hDEADBEEF);
    chk("ovf_wren", ram_wren, 0);
    chk("ovf_drop_count", drop_count, 2);
    send(0, 0, 0, 32'h12345678);
    chk("drop_wren", ram_wren, 0);
    send(0, 1, 0, 32'h87654321);
    chk("drop_eop_wren", ram_wren, 0);
    step;
    chk("drop_frame_ready", frame_ready, 0);
    chk("drop_in_ready", in_ready, 1);

    send(1, 0, 0, 32'd0);
    for (int i = 1; i < 511; i++) send(0, 0, 0, 32'(i));
    send(0, 1, 0, 32'd511);
    chk("full_addr", ram_address, 511);
    chk("full_wren", ram_wren, 1);
    step;
    chk("full_frame_ready", frame_ready, 1);
    chk("full_frame_len", frame_len, 2048);
    chk("full_drop_count", drop_count, 2);
    release_frame;

    send(1, 0, 0, 32'h13579BDF);
    send(0, 0, 0, 32'h2468ACE0);
    #2 reset = 1;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_wren", ram_wren, 0);
    chk("arst_addr", ram_address, 0);
    chk("arst_data", ram_data, 0);
    chk("arst_be", ram_byteena, 0);
    chk("arst_frame_ready", frame_ready, 0);
    chk("arst_frame_len", frame_len, 0);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_rd_data", rd_data, 0);
    chk("arst_drop_count", drop_count, 0);
    @(posedge clock); #1 reset = 0;
    send(1, 1, 1, 32'hCAFEF00D);
    chk("post_addr", ram_address, 0);
    chk("post_be", ram_byteena, 4'b1110);
    step;
    chk("post_frame_ready", frame_ready, 1);
    chk("post_frame_len", frame_len, 3);
    release_frame;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
